i2c_byte_master: RTL and testbench

Hardware I2C byte-level master that replaces software bit-banging of the SDA/SCL pins. It is an Avalon-MM slave on the CPU side. On the bus side it drives two open-drain pins: SCL is pulled low or released, and SDA is pulled low or released. Each command performs an optional START, one 8-bit transfer with its ACK bit, and an optional STOP. It sits between the CPU bus and the board I2C pins, in place of the SDA/SCL PIO pair.

---
 rtl/i2c_master_pkg.sv | 29 ++
 rtl/i2c_tick_gen.sv | 36 +++
 rtl/i2c_byte_master.sv | 174 +++++++++++++++++
 tb/tb_i2c_byte_master.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_pkg
// Description : Shared state encoding, register map and CMD field positions
//               for the I2C byte master.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic [1:0] c_addr_cmd    = 2'd0;
  localparam logic [1:0] c_addr_status = 2'd1;
  localparam logic [1:0] c_addr_rxdata = 2'd2;
  localparam logic [1:0] c_addr_div    = 2'd3;

  localparam int c_cmd_start = 8;
  localparam int c_cmd_stop  = 9;
  localparam int c_cmd_read  = 10;
  localparam int c_cmd_nack  = 11;

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tick_gen
// Description : Quarter-bit tick generator; down-counter reloaded from div,
//               with synchronous restart (clear) and stall-at-zero (hold).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  input  logic             clear,
  input  logic             hold,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= div;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end else if (!hold) begin
      r_cnt <= div;
    end
  end

  assign tick = (r_cnt == '0) && !hold && !clear;

endmodule
`default_nettype wire

// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : i2c_byte_master
// Description : Avalon-MM I2C byte master (START / 8 bits + ACK / STOP).
//               Optional macro I2C_CLOCK_STRETCH_EN enables slave clock
//               stretching in q1 of BIT, ACK and STOP.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_byte_master
  import i2c_master_pkg::*;
#(
  parameter int          DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 124
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  inout  wire         scl_port,
  inout  wire         sda_port
);

  state_t           r_state;
  logic [1:0]       r_q;
  logic [2:0]       r_bit;
  logic [7:0]       r_tx;
  logic             r_stop, r_read, r_nack;
  logic             r_rx_ack;
  logic [7:0]       r_rxdata;
  logic [DIV_W-1:0] r_div;
  logic             r_scl_low, r_sda_low;

  state_t           w_next_state;
  logic [1:0]       w_next_q;
  logic [2:0]       w_next_bit;
  logic [7:0]       w_next_tx;
  logic             w_next_stop, w_next_read, w_next_nack;
  logic             w_data_bit, w_scl_low, w_sda_low;
  logic             w_busy, w_accept, w_div_wr, w_tick, w_hold;
  logic [31:0]      w_rdata;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = chipselect && !write_n && (address == c_addr_cmd) && !w_busy;
  assign w_div_wr = chipselect && !write_n && (address == c_addr_div);

  assign scl_port = r_scl_low ? 1'b0 : 1'bz;
  assign sda_port = r_sda_low ? 1'b0 : 1'bz;

`ifdef I2C_CLOCK_STRETCH_EN
  assign w_hold = ((r_state == ST_BIT) || (r_state == ST_ACK) || (r_state == ST_STOP))
                  && (r_q == 2'd1) && !scl_port;
`else
  assign w_hold = 1'b0;
`endif

  i2c_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .div     (r_div),
    .clear   (w_accept),
    .hold    (w_hold),
    .tick    (w_tick)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_q     = r_q;
    w_next_bit   = r_bit;
    w_next_tx    = r_tx;
    w_next_stop  = r_stop;
    w_next_read  = r_read;
    w_next_nack  = r_nack;
    if (r_state == ST_IDLE) begin
      if (w_accept) begin
        w_next_state = writedata[c_cmd_start] ? ST_START : ST_BIT;
        w_next_q     = 2'd0;
        w_next_bit   = 3'd7;
        w_next_tx    = writedata[7:0];
        w_next_stop  = writedata[c_cmd_stop];
        w_next_read  = writedata[c_cmd_read];
        w_next_nack  = writedata[c_cmd_nack];
      end
    end else if (w_tick) begin
      w_next_q = r_q + 2'd1;
      if (r_q == 2'd3) begin
        unique case (r_state)
          ST_START: w_next_state = ST_BIT;
          ST_BIT: begin
            if (r_bit == 3'd0) w_next_state = ST_ACK;
            else               w_next_bit   = r_bit - 3'd1;
          end
          ST_ACK:  w_next_state = r_stop ? ST_STOP : ST_IDLE;
          default: w_next_state = ST_IDLE;
        endcase
      end
    end
  end

  // Pin levels are derived from the quarter being entered so they register on the same edge.
  always_comb begin
    w_data_bit = 1'b1;
    if (w_next_state == ST_BIT)      w_data_bit = w_next_read | w_next_tx[w_next_bit];
    else if (w_next_state == ST_ACK) w_data_bit = ~w_next_read | w_next_nack;
    w_scl_low = r_scl_low;
    w_sda_low = r_sda_low;
    unique case (w_next_state)
      ST_IDLE: w_sda_low = 1'b0;
      ST_START: begin
        if (w_next_q == 2'd0) begin w_scl_low = 1'b0; w_sda_low = 1'b0; end
        else if (w_next_q == 2'd2) w_sda_low = 1'b1;
        else if (w_next_q == 2'd3) w_scl_low = 1'b1;
      end
      ST_BIT, ST_ACK: begin
        if (w_next_q == 2'd0) begin w_scl_low = 1'b1; w_sda_low = ~w_data_bit; end
        else if (w_next_q == 2'd1) w_scl_low = 1'b0;
        else if (w_next_q == 2'd3) w_scl_low = 1'b1;
      end
      default: begin
        if (w_next_q == 2'd0) begin w_scl_low = 1'b1; w_sda_low = 1'b1; end
        else if (w_next_q == 2'd1) w_scl_low = 1'b0;
        else if (w_next_q == 2'd2) w_sda_low = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_rdata = '0;
    unique case (address)
      c_addr_status: w_rdata[1:0]       = {r_rx_ack, w_busy};
      c_addr_rxdata: w_rdata[7:0]       = r_rxdata;
      c_addr_div:    w_rdata[DIV_W-1:0] = r_div;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_q       <= 2'd0;
      r_bit     <= 3'd7;
      r_tx      <= 8'd0;
      r_stop    <= 1'b0;
      r_read    <= 1'b0;
      r_nack    <= 1'b0;
      r_rx_ack  <= 1'b0;
      r_rxdata  <= 8'd0;
      r_div     <= DIV_W'(DEFAULT_DIV);
      r_scl_low <= 1'b0;
      r_sda_low <= 1'b0;
      readdata  <= 32'd0;
    end else begin
      r_state   <= w_next_state;
      r_q       <= w_next_q;
      r_bit     <= w_next_bit;
      r_tx      <= w_next_tx;
      r_stop    <= w_next_stop;
      r_read    <= w_next_read;
      r_nack    <= w_next_nack;
      r_scl_low <= w_scl_low;
      r_sda_low <= w_sda_low;
      readdata  <= w_rdata;
      if (w_tick && (r_q == 2'd2)) begin
        if ((r_state == ST_BIT) && r_read)  r_rxdata <= {r_rxdata[6:0], sda_port};
        if ((r_state == ST_ACK) && !r_read) r_rx_ack <= sda_port;
      end
      if (w_div_wr) r_div <= writedata[DIV_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_byte_master
// Description : Directed bench for i2c_byte_master with a bus-level slave
//               model; covers I2C_CLOCK_STRETCH_EN when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd1;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  wire         scl_bus;
  wire         sda_bus;

  logic        slave_scl_low = 1'b0;
  logic        slave_sda_low = 1'b0;
  int          slave_mode = 0;        // 0 write/ACK, 1 write/NACK, 2 read
  logic [7:0]  slave_byte = 8'd0;
  logic        stretch_on = 1'b0;
  int          stretch_cnt = 0;

  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic [3:0]  rise_cnt = 4'd0;
  logic [7:0]  mon_byte = 8'd0;
  logic        mon_ack = 1'b0;
  logic        stop_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  pullup (scl_bus);
  pullup (sda_bus);
  assign scl_bus = slave_scl_low ? 1'b0 : 1'bz;
  assign sda_bus = slave_sda_low ? 1'b0 : 1'bz;

  i2c_byte_master #(.DIV_W(16), .DEFAULT_DIV(124)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .scl_port   (scl_bus),
    .sda_port   (sda_bus)
  );

  always #5 clk = ~clk;

  // Bus monitor and slave: data changes only while SCL is low.
  always @(negedge clk) begin
    prev_scl <= scl_bus;
    prev_sda <= sda_bus;
    if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
      rise_cnt  <= 4'd0;
      stop_seen <= 1'b0;
    end else if (prev_scl && scl_bus && !prev_sda && sda_bus) begin
      stop_seen <= 1'b1;
    end else if (!prev_scl && scl_bus) begin
      if (rise_cnt < 4'd8)  mon_byte <= {mon_byte[6:0], sda_bus};
      if (rise_cnt == 4'd8) mon_ack  <= sda_bus;
      if (rise_cnt != 4'd15) rise_cnt <= rise_cnt + 4'd1;
    end
    if (!scl_bus) begin
      case (slave_mode)
        0:       slave_sda_low <= (rise_cnt == 4'd8);
        2:       slave_sda_low <= (rise_cnt < 4'd8) && !slave_byte[3'd7 - rise_cnt[2:0]];
        default: slave_sda_low <= 1'b0;
      endcase
    end
    // SCL held low 22 clocks from the fall; the master's own low phase is 2 of them.
    if (stretch_cnt != 0) begin
      stretch_cnt <= stretch_cnt - 1;
      if (stretch_cnt == 1) slave_scl_low <= 1'b0;
    end else if (stretch_on && prev_scl && !scl_bus && rise_cnt == 4'd3) begin
      slave_scl_low <= 1'b1;
      stretch_cnt   <= 22;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
    address = 2'd1;
  endtask

  // Counts samples with busy=1 after a CMD write; optionally issues a
  // competing CMD write (whose address-0 read-back sample is counted as busy).
  task automatic count_busy(input bit intrude, output int n);
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (intrude && i == 11) begin
        n++;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
      end else if (readdata[0]) begin
        n++;
      end else begin
        break;
      end
      if (intrude && i == 10) begin
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h0000_0F00;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          n;
    bit          hit;

    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd1, d); check_value("reset_status", d, 32'h0);
    bus_read(2'd2, d); check_value("reset_rxdata", d, 32'h0);
    bus_read(2'd3, d); check_value("reset_div", d, 32'd124);
    check_value("reset_scl", {31'd0, scl_bus}, 32'd1);
    check_value("reset_sda", {31'd0, sda_bus}, 32'd1);

    // START + write 0xA5 + STOP, DIV=0, slave ACKs
    slave_mode = 0;
    bus_write(2'd3, 32'd0);
    bus_read(2'd3, d); check_value("div_wr0", d, 32'd0);
    bus_write(2'd0, 32'h0000_03A5);
    count_busy(1'b0, n);
    check_value("wr_busy_len", n, 32'd44);
    check_value("wr_bits", {24'd0, mon_byte}, 32'hA5);
    check_value("wr_stop", {31'd0, stop_seen}, 32'd1);
    bus_read(2'd1, d); check_value("wr_status_ack", d, 32'h0);
    check_value("wr_idle_scl", {31'd0, scl_bus}, 32'd1);
    check_value("wr_idle_sda", {31'd0, sda_bus}, 32'd1);

    // START + write 0x3C, no STOP, DIV=3, slave NACKs
    slave_mode = 1;
    bus_write(2'd3, 32'd3);
    bus_read(2'd3, d); check_value("div_wr3", d, 32'd3);
    bus_write(2'd0, 32'h0000_013C);
    count_busy(1'b0, n);
    check_value("nack_busy_len", n, 32'd160);
    check_value("nack_bits", {24'd0, mon_byte}, 32'h3C);
    bus_read(2'd1, d); check_value("nack_status", d, 32'h2);
    check_value("nack_scl_low", {31'd0, scl_bus}, 32'd0);
    check_value("nack_sda_rel", {31'd0, sda_bus}, 32'd1);
    check_value("nack_no_stop", {31'd0, stop_seen}, 32'd0);

    // START + read with NACK + STOP, DIV=0, slave sends 0x5A
    slave_mode = 2;
    slave_byte = 8'h5A;
    bus_write(2'd3, 32'd0);
    bus_write(2'd0, 32'h0000_0F00);
    count_busy(1'b0, n);
    check_value("rd_busy_len", n, 32'd44);
    bus_read(2'd2, d); check_value("rd_rxdata", d, 32'h5A);
    check_value("rd_ack_slot", {31'd0, mon_ack}, 32'd1);
    check_value("rd_stop", {31'd0, stop_seen}, 32'd1);
    bus_read(2'd1, d); check_value("rd_status", d, 32'h2);

    // CMD write while busy is ignored
    slave_mode = 0;
    bus_write(2'd3, 32'd3);
    bus_write(2'd0, 32'h0000_03FF);
    count_busy(1'b1, n);
    check_value("busy_wr_len", n, 32'd176);
    check_value("busy_wr_bits", {24'd0, mon_byte}, 32'hFF);
    bus_read(2'd2, d); check_value("busy_wr_rxdata", d, 32'h5A);
    bus_read(2'd1, d); check_value("busy_wr_status", d, 32'h0);

    // Reset mid-byte while SCL is pulled low
    bus_write(2'd0, 32'h0000_03A5);
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rise_cnt == 4'd3 && !scl_bus) begin
        hit = 1'b1;
        break;
      end
    end
    check_value("midbyte_reached", {31'd0, hit}, 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_value("rst_scl_rel", {31'd0, scl_bus}, 32'd1);
    check_value("rst_sda_rel", {31'd0, sda_bus}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd1, d); check_value("rst_status", d, 32'h0);
    bus_read(2'd3, d); check_value("rst_div", d, 32'd124);

`ifdef I2C_CLOCK_STRETCH_EN
    // Slave stretches SCL during bit 3; busy grows by exactly 20 clocks
    slave_mode = 0;
    bus_write(2'd3, 32'd0);
    stretch_on = 1'b1;
    bus_write(2'd0, 32'h0000_03A5);
    count_busy(1'b0, n);
    stretch_on = 1'b0;
    check_value("stretch_busy_len", n, 32'd64);
    check_value("stretch_bits", {24'd0, mon_byte}, 32'hA5);
    bus_read(2'd1, d); check_value("stretch_status", d, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
